// File: rtl/ysyx_25070198_lsu.sv
// Load-store unit: runs one execute-stage memory request at a time on the data-side SimpleBus.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus cycle.
module ysyx_25070198_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        bus_req,
  output logic        bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        done,
  output logic        err,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  localparam logic [15:0] LP_LAST_WAIT = 16'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [4:0]  r_rd;
  logic [15:0] r_cnt;
  logic        r_done;
  logic        r_err;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        w_misalign;
  logic        w_timeout;

  function automatic logic [3:0] f_store_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    f_store_mask = 4'b0001 << a;
      2'd1:    f_store_mask = 4'b0011 << {a[1], 1'b0};
      default: f_store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    f_store_data = {4{wdata[7:0]}};
      2'd1:    f_store_data = {2{wdata[15:0]}};
      default: f_store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] f_load_extract(input logic [31:0] rdata, input logic [1:0] a,
                                                 input logic [1:0] size, input logic uns);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] sx;
    b  = rdata[{a, 3'b000} +: 8];
    h  = rdata[{a[1], 4'b0000} +: 16];
    sx = '0;
    case (size)
      2'd0: begin
        sx = $signed(b);
        f_load_extract = uns ? {24'h0, b} : sx;
      end
      2'd1: begin
        sx = $signed(h);
        f_load_extract = uns ? {16'h0, h} : sx;
      end
      default: f_load_extract = rdata;
    endcase
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // ack takes priority over timeout wherever both apply
  assign w_timeout = (r_cnt == LP_LAST_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_state_nxt = w_misalign ? S_DONE : S_BUS;
      S_BUS:  if (bus_ack || w_timeout) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wen      <= req_wen;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_rd       <= req_rd;
            r_cnt      <= '0;
            if (w_misalign) begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_wb_rd <= req_rd;
            end
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            r_done  <= 1'b1;
            r_wb_rd <= r_rd;
            if (!r_wen) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= f_load_extract(bus_rdata, r_addr[1:0], r_size, r_unsigned);
            end
          end else if (w_timeout) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_wb_rd <= r_rd;
            if (!r_wen) r_wb_data <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign bus_req   = (r_state == S_BUS);
  assign bus_wen   = bus_req & r_wen;
  assign bus_addr  = {r_addr[31:2], 2'b00};
  assign bus_wdata = f_store_data(r_size, r_wdata);
  assign bus_wmask = bus_wen ? f_store_mask(r_size, r_addr[1:0]) : 4'b0000;
  assign done      = r_done;
  assign err       = r_err;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;

endmodule

// File: tb/tb_ysyx_25070198_lsu.sv
// Scoreboard bench for ysyx_25070198_lsu: stimulus pushes expected bus/completion records, a monitor pops and compares.
module tb_ysyx_25070198_lsu;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        bus_req;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        done;
  logic        err;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  ysyx_25070198_lsu #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned), .req_rd(req_rd),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .done(done), .err(err), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          cycles;
  } bexp_t;

  typedef struct {
    int          acc;
    int          lat;
    logic        err;
    logic        wbv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
  } dexp_t;

  bexp_t bq[$];
  dexp_t dq[$];
  int n_checks = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  bexp_t cur_b;
  logic  in_bus = 1'b0;
  int    bcnt = 0;

  // monitor: bus-side fields and completion pulses
  initial begin
    dexp_t d;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus_req) begin
          if (!in_bus) begin
            if (bq.size() == 0) chk("unexpected_bus_req", {31'b0, bus_req}, 32'd0);
            else begin
              cur_b = bq.pop_front();
              in_bus = 1'b1;
              bcnt = 0;
            end
          end
          if (in_bus) begin
            bcnt++;
            chk("bus_addr", bus_addr, cur_b.addr);
            chk("bus_wen", {31'b0, bus_wen}, {31'b0, cur_b.wen});
            chk("bus_wmask", {28'b0, bus_wmask}, {28'b0, cur_b.mask});
            chk("bus_wdata", bus_wdata, cur_b.wdata);
          end
        end
        if (wb_valid && !done) chk("wb_valid_without_done", {31'b0, wb_valid}, {31'b0, done});
        if (done) begin
          if (dq.size() == 0) chk("unexpected_done", {31'b0, done}, 32'd0);
          else begin
            d = dq.pop_front();
            chk("latency", cyc - d.acc, d.lat);
            chk("err", {31'b0, err}, {31'b0, d.err});
            chk("wb_valid", {31'b0, wb_valid}, {31'b0, d.wbv});
            if (d.wbv) chk("wb_rd", {27'b0, wb_rd}, {27'b0, d.rd});
            if (d.chk_data) chk("wb_data", wb_data, d.data);
          end
        end
      end
      if (!bus_req && in_bus) begin
        chk("bus_req_cycles", bcnt, cur_b.cycles);
        in_bus = 1'b0;
      end
    end
  end

  // waits < 0: never acknowledge; has_bus = 0: no bus cycle expected
  task automatic run_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [4:0] rd,
                         input int waits, input logic [31:0] rdata, input logic has_bus,
                         input logic [31:0] e_addr, input logic [3:0] e_mask,
                         input logic [31:0] e_wdata, input logic e_err, input logic [31:0] e_data);
    bexp_t b;
    dexp_t d;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; req_rd = rd;
    d.acc = cyc;
    d.lat = !has_bus ? 1 : (waits < 0 ? 1 + MAXW : 2 + waits);
    d.err = e_err;
    d.wbv = !wen && !e_err;
    d.rd = rd;
    d.data = e_data;
    d.chk_data = !wen;
    dq.push_back(d);
    if (has_bus) begin
      b.addr = e_addr; b.wen = wen; b.mask = e_mask; b.wdata = e_wdata;
      b.cycles = (waits < 0) ? MAXW : waits + 1;
      bq.push_back(b);
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (has_bus) begin
      if (waits >= 0) begin
        repeat (waits) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = rdata;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
      end else begin
        repeat (MAXW) @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_wen", {31'b0, bus_wen}, 32'd0);
    chk("rst_bus_wmask", {28'b0, bus_wmask}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // sw
    run_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 5'd0, 0, 32'h0, 1'b1,
            32'h8000_0010, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0);
    // sb
    run_req(1'b1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 5'd0, 0, 32'h0, 1'b1,
            32'h8000_0000, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0);
    // sh upper half
    run_req(1'b1, 32'h8000_0102, 32'h1234_BEEF, 2'd1, 1'b0, 5'd0, 1, 32'h0, 1'b1,
            32'h8000_0100, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0);
    // lb, 3 waits: ack lands on the last allowed wait cycle
    run_req(1'b0, 32'h8000_0002, 32'h0, 2'd0, 1'b0, 5'd7, 3, 32'h12F4_5678, 1'b1,
            32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'hFFFF_FFF4);
    // lbu, same access
    run_req(1'b0, 32'h8000_0002, 32'h0, 2'd0, 1'b1, 5'd8, 3, 32'h12F4_5678, 1'b1,
            32'h8000_0000, 4'b0000, 32'h0, 1'b0, 32'h0000_00F4);
    // lh upper half, sign-extended
    run_req(1'b0, 32'h8000_0042, 32'h0, 2'd1, 1'b0, 5'd9, 0, 32'h8001_1234, 1'b1,
            32'h8000_0040, 4'b0000, 32'h0, 1'b0, 32'hFFFF_8001);
    // lhu lower half
    run_req(1'b0, 32'h8000_0040, 32'h0, 2'd1, 1'b1, 5'd10, 0, 32'h8001_F234, 1'b1,
            32'h8000_0040, 4'b0000, 32'h0, 1'b0, 32'h0000_F234);
    // load timeout: no ack
    run_req(1'b0, 32'h8000_0080, 32'h0, 2'd2, 1'b0, 5'd11, -1, 32'h0, 1'b1,
            32'h8000_0080, 4'b0000, 32'h0, 1'b1, 32'h0);
    // lw to x0 right after the timeout, size 3 treated as word
    run_req(1'b0, 32'h8000_0020, 32'h0, 2'd3, 1'b0, 5'd0, 2, 32'hCAFE_F00D, 1'b1,
            32'h8000_0020, 4'b0000, 32'h0, 1'b0, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_CHECK_EN
    run_req(1'b0, 32'h8000_0006, 32'h0, 2'd2, 1'b0, 5'd12, 0, 32'h0, 1'b0,
            32'h0, 4'b0000, 32'h0, 1'b1, 32'hCAFE_F00D);
`else
    run_req(1'b0, 32'h8000_0006, 32'h0, 2'd2, 1'b0, 5'd12, 0, 32'h1357_9BDF, 1'b1,
            32'h8000_0004, 4'b0000, 32'h0, 1'b0, 32'h1357_9BDF);
`endif

    // stray ack while idle
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = '0;
    chk("stray_ack_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);

    // reset while in BUS
    begin
      bexp_t b;
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0200;
      req_wdata = 32'h0102_0304; req_size = 2'd2; req_unsigned = 1'b0; req_rd = 5'd3;
      b.addr = 32'h8000_0200; b.wen = 1'b1; b.mask = 4'b1111; b.wdata = 32'h0102_0304; b.cycles = 2;
      bq.push_back(b);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_bus_req", {31'b0, bus_req}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("release_req_ready", {31'b0, req_ready}, 32'd1);
      repeat (4) @(negedge clk);
    end

    chk("done_queue_empty", dq.size(), 32'd0);
    chk("bus_queue_empty", bq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_25070198_lsu.md
# ysyx_25070198_lsu

Load-store unit between the execute stage and the register file. It accepts one memory request at a time from the execute stage and runs it on the data-side SimpleBus with a valid/ack handshake. For loads it returns the byte lane selected by the address, sign- or zero-extended. It also reports completion, so the fetch stage does not advance the PC while a memory instruction is still in flight.

## Interface
- `MAX_WAIT`, default 255: bus-ack timeout in cycles, counted while in BUS; legal range 1..65535.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute stage presents a request.
- `req_ready` out 1: LSU can accept a request; high only in IDLE.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address (rs1 + imm).
- `req_wdata` in 32: store data, right-aligned (rs2).
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_unsigned` in 1: zero-extend load result (lbu/lhu).
- `req_rd` in 5: load destination register.
- `bus_req` out 1: bus request; held high until acked.
- `bus_wen` out 1: write strobe.
- `bus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_wmask` out 4: byte-lane enables; 0 on loads.
- `bus_ack` in 1: bus accepts/completes the transfer; read data valid in the same cycle.
- `bus_rdata` in 32: read data.
- `done` out 1: one-cycle pulse when a request finishes (load or store).
- `err` out 1: qualifies `done`; the access timed out or was misaligned.
- `wb_valid` out 1: one-cycle pulse; load result ready for the register file.
- `wb_rd` out 5: destination register for the write-back.
- `wb_data` out 32: extended load data.

## Operation
- **States:** IDLE, BUS, DONE.
  - Reset enters IDLE.
- **IDLE:**
  - `req_ready`=1.
  - When `req_valid` is high at a clock edge, latch wen/addr/wdata/size/unsigned/rd and go to BUS.
  - A misaligned request with `LSU_MISALIGN_CHECK_EN` defined goes to DONE instead (see Configuration).
- **BUS:**
  - `bus_req`=1; `bus_addr`, `bus_wen`, `bus_wdata` and `bus_wmask` are driven from the latched fields and are stable until ack.
  - `bus_ack`=1 at an edge: capture `bus_rdata` and go to DONE.
  - The wait counter resets on entry to BUS. If it reaches `MAX_WAIT` without an ack, go to DONE with err set and load data 0.
- **DONE:**
  - `done`=1 for one cycle, with `err` as recorded.
  - `wb_valid`=1 only if the access was a load and `err`=0.
  - Always returns to IDLE next cycle; `req_valid` is ignored in DONE.
- **Store lanes** (a = latched addr[1:0]):
  - byte: mask `4'b0001<<a`, wdata `{4{wdata[7:0]}}`.
  - half: mask `4'b0011<<{a[1],1'b0}`, wdata `{2{wdata[15:0]}}`.
  - word: mask `4'b1111`, wdata unchanged.
- **Load extract:**
  - byte = `rdata[8a+7:8a]`.
  - half = `rdata[16a[1]+15:16a[1]]`.
  - Extend to 32 bits: zero-extend if unsigned, else sign-extend; word is passed through.
- **rd = x0:** `wb_valid` still pulses with `wb_rd`=0; the register file drops the write.

## Timing
- **Reset values:**
  - State IDLE and the wait counter 0.
  - `req_ready`=1.
  - `bus_req`, `bus_wen`, `bus_wmask`, `done`, `err` and `wb_valid` are 0.
  - `bus_addr`, `bus_wdata`, `wb_rd` and `wb_data` are 0.
- **Latency:**
  - Acceptance at edge T0, so `bus_req` is high in cycle T0..T1.
  - If the ack is sampled at edge T1, `done`/`wb_valid` are high in cycle T1..T2.
  - Minimum latency is 2 cycles from accept to done; each extra wait cycle adds 1.
- **Handshake:** `bus_req` never drops before ack or timeout, and the address/data fields never change while `bus_req` is high.
- **Ack and timeout in the same cycle:** the ack wins and `err`=0.
- **Reset mid-operation:** asserting `rst` in any state forces `bus_req` and all pulses low asynchronously; no `done` is produced for the aborted request.
- **Stray `bus_ack`** outside BUS is ignored.
- `done`, `wb_valid`, `wb_rd` and `wb_data` are registered outputs. `req_ready` is decoded from state.

## Configuration
- **`LSU_MISALIGN_CHECK_EN` defined:**
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - It issues no bus request and goes IDLE→DONE, with `done`=1, `err`=1 and `wb_valid`=0 one cycle after acceptance.
- **`LSU_MISALIGN_CHECK_EN` not defined:**
  - No check is made; misaligned accesses are issued normally.
  - Half ignores addr[0], and word ignores addr[1:0].

## Test plan
- Store word: addr 0x80000010, data 0xDEADBEEF, ack on the first BUS cycle -> `bus_addr`=0x80000010, `bus_wmask`=1111, `done` 2 cycles after accept, `wb_valid`=0.
- Store byte: addr 0x80000003, data 0x000000A5 -> `bus_wmask`=1000, `bus_wdata`=0xA5A5A5A5, `bus_addr`=0x80000000.
- Load signed byte (lb) from addr 0x80000002 with rdata 0x12F45678, ack after 3 wait cycles -> `wb_data`=0xFFFFFFF4, `wb_rd`=latched rd, `done` 5 cycles after accept.
  - The same load as lbu returns 0x000000F4.
- No ack, `MAX_WAIT`=4 -> `bus_req` high for 4 cycles, then `done`=1 with `err`=1 and `wb_valid`=0; the next request is accepted normally.
- Load word from addr 0x80000006 -> with the macro defined, `err`=1 and no `bus_req` ever; with the macro undefined, `bus_addr`=0x80000004 and `wb_data`=`bus_rdata`.
- Assert `rst` low while in BUS -> `bus_req` drops immediately, and there is no `done` after release.
  - `req_ready`=1 on the first cycle after release.
